// File: rtl/psg_bus_master.sv
`default_nettype none
// ============================================================================
//  Module   : psg_bus_master
//  Purpose  : Bus initiator for the AY-3-8912 compatible PSG. Queues register
//             writes in a small FIFO, accepts single register reads, and
//             sequences bdir/bc1/d phases (ADDR, WDATA, RDATA, GAP) on ce.
//  Revision : 1.0 - initial release
// ============================================================================
module psg_bus_master #(
  parameter logic [3:0] ADDRMASK   = 4'b0000,
  parameter int         DEPTH_LOG2 = 3,
  parameter bit         ADDR_CACHE = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [3:0] wr_reg,
  input  logic [7:0] wr_data,
  input  logic       rd_valid,
  output logic       rd_ready,
  input  logic [3:0] rd_reg,
  output logic [7:0] rd_data,
  output logic       rd_done,
  output logic       bdir,
  output logic       bc1,
  output logic [7:0] d,
  input  logic [7:0] q,
  output logic       busy
);

  localparam int unsigned         c_DEPTH_INT = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_DEPTH     = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WDATA = 3'd2,
    S_RDATA = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  // FSM and bus
  state_t              r_state;
  state_t              w_state_next;
  logic                r_bdir;
  logic                r_bc1;
  logic [7:0]          r_d;
  logic [9:0]          w_bus_next;

  // operation in flight
  logic                r_op_read;
  logic [3:0]          r_op_reg;
  logic [7:0]          r_op_data;
  logic                w_load_op;
  logic                w_op_read_next;
  logic [3:0]          w_op_reg_next;
  logic [7:0]          w_op_data_next;

  // address cache
  logic                r_cache_valid;
  logic [3:0]          r_cache_reg;
  logic                w_cache_upd;
  logic                w_hit_head;
  logic                w_hit_rd;

  // write FIFO
  logic [11:0]         r_mem [0:c_DEPTH_INT-1];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0] r_count;
  logic [DEPTH_LOG2:0] w_count_next;
  logic                r_wr_ready;
  logic                w_push;
  logic                w_pop;
  logic [11:0]         w_head;
  logic [3:0]          w_head_reg;
  logic [7:0]          w_head_data;

  // read path
  logic                r_rd_pending;
  logic [3:0]          r_rd_reg;
  logic [7:0]          r_rd_data;
  logic                r_rd_done;
  logic                w_rd_capture;

  assign w_push      = wr_valid && r_wr_ready;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_reg  = w_head[11:8];
  assign w_head_data = w_head[7:0];

  // A hit means the PSG already holds this register address, so ADDR is skipped
  generate
    if (ADDR_CACHE) begin : g_cache
      assign w_hit_head = r_cache_valid && (w_head_reg == r_cache_reg);
      assign w_hit_rd   = r_cache_valid && (r_rd_reg == r_cache_reg);
    end else begin : g_no_cache
      assign w_hit_head = 1'b0;
      assign w_hit_rd   = 1'b0;
    end
  endgenerate

  // Next state, dispatch decisions and next bus phase encoding
  always_comb begin
    w_state_next   = r_state;
    w_pop          = 1'b0;
    w_load_op      = 1'b0;
    w_op_read_next = r_op_read;
    w_op_reg_next  = r_op_reg;
    w_op_data_next = r_op_data;
    w_cache_upd    = 1'b0;
    w_rd_capture   = 1'b0;
    w_bus_next     = 10'd0;

    if (ce) begin
      case (r_state)
        // GAP dispatches like IDLE so queued work costs no extra idle period
        S_IDLE, S_GAP: begin
          if (r_count != '0) begin
            w_pop          = 1'b1;
            w_load_op      = 1'b1;
            w_op_read_next = 1'b0;
            w_op_reg_next  = w_head_reg;
            w_op_data_next = w_head_data;
            w_state_next   = w_hit_head ? S_WDATA : S_ADDR;
          end else if (r_rd_pending) begin
            w_load_op      = 1'b1;
            w_op_read_next = 1'b1;
            w_op_reg_next  = r_rd_reg;
            w_op_data_next = 8'h00;
            w_state_next   = w_hit_rd ? S_RDATA : S_ADDR;
          end else begin
            w_state_next   = S_IDLE;
          end
        end
        S_ADDR: begin
          w_cache_upd  = 1'b1;
          w_state_next = r_op_read ? S_RDATA : S_WDATA;
        end
        S_WDATA: begin
          w_state_next = S_GAP;
        end
        S_RDATA: begin
          w_rd_capture = 1'b1;
          w_state_next = S_GAP;
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end

    case (w_state_next)
      S_ADDR:  w_bus_next = {2'b11, ADDRMASK, w_op_reg_next};
      S_WDATA: w_bus_next = {2'b10, w_op_data_next};
      S_RDATA: w_bus_next = {2'b01, 8'h00};
      default: w_bus_next = 10'd0;
    endcase
  end

  // FSM state and registered bus phase, advanced only on ce
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_bdir  <= 1'b0;
      r_bc1   <= 1'b0;
      r_d     <= 8'h00;
    end else if (ce) begin
      r_state <= w_state_next;
      r_bdir  <= w_bus_next[9];
      r_bc1   <= w_bus_next[8];
      r_d     <= w_bus_next[7:0];
    end
  end

  // Capture the operation being issued so later phases do not depend on FIFO head
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_op_read <= 1'b0;
      r_op_reg  <= 4'h0;
      r_op_data <= 8'h00;
    end else if (w_load_op) begin
      r_op_read <= w_op_read_next;
      r_op_reg  <= w_op_reg_next;
      r_op_data <= w_op_data_next;
    end
  end

  // Remember the register address last latched into the PSG
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cache_valid <= 1'b0;
      r_cache_reg   <= 4'h0;
    end else if (w_cache_upd) begin
      r_cache_valid <= 1'b1;
      r_cache_reg   <= r_op_reg;
    end
  end

  // FIFO occupancy after this clock's push and pop
  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - 1'b1;
    end
  end

  // FIFO pointers, count and registered not-full flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_wr_ready <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count    <= w_count_next;
      r_wr_ready <= (w_count_next != c_DEPTH);
    end
  end

  // FIFO storage; contents are don't-care until pointed to by a valid count
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {wr_reg, wr_data};
    end
  end

  // Read request acceptance, completion pulse and returned data
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rd_pending <= 1'b0;
      r_rd_reg     <= 4'h0;
      r_rd_data    <= 8'h00;
      r_rd_done    <= 1'b0;
    end else begin
      r_rd_done <= w_rd_capture;
      if (w_rd_capture) begin
        r_rd_data    <= q;
        r_rd_pending <= 1'b0;
      end else if (rd_valid && !r_rd_pending) begin
        r_rd_pending <= 1'b1;
        r_rd_reg     <= rd_reg;
      end
    end
  end

  assign wr_ready = r_wr_ready;
  assign rd_ready = !r_rd_pending;
  assign rd_data  = r_rd_data;
  assign rd_done  = r_rd_done;
  assign bdir     = r_bdir;
  assign bc1      = r_bc1;
  assign d        = r_d;
  assign busy     = (r_state != S_IDLE) || (r_count != '0) || r_rd_pending;

endmodule
`default_nettype wire

// File: tb/tb_psg_bus_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_psg_bus_master
//  Purpose  : Self-checking bench for psg_bus_master with a small PSG model,
//             a write scoreboard and per-ce-period bus phase log.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_psg_bus_master;

  logic       clock    = 1'b0;
  logic       reset    = 1'b0;
  logic       ce       = 1'b0;
  logic       wr_valid = 1'b0;
  logic [3:0] wr_reg   = 4'h0;
  logic [7:0] wr_data  = 8'h00;
  logic       rd_valid = 1'b0;
  logic [3:0] rd_reg   = 4'h0;
  logic       wr_ready;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic       rd_done;
  logic       bdir;
  logic       bc1;
  logic [7:0] d;
  logic [7:0] q;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  bit ce_run   = 1'b0;

  psg_bus_master #(
    .ADDRMASK   (4'b0000),
    .DEPTH_LOG2 (3),
    .ADDR_CACHE (1'b1)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .ce       (ce),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_reg   (wr_reg),
    .wr_data  (wr_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_reg   (rd_reg),
    .rd_data  (rd_data),
    .rd_done  (rd_done),
    .bdir     (bdir),
    .bc1      (bc1),
    .d        (d),
    .q        (q),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  // ce: every other clock while running, changed 2ns after the rising edge
  initial begin
    forever begin
      @(posedge clock);
      #2;
      ce = ce_run ? ~ce : 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- PSG model, phase log and write scoreboard ----------------
  logic [7:0]  psg_regs [0:15];
  logic [3:0]  psg_addr;
  int          env_resets = 0;
  logic [9:0]  phase_log [$];
  logic [11:0] exp_wr_q [$];
  logic [11:0] sb_exp;

  assign q = psg_regs[psg_addr];

  // At the negedge before a ce edge the bus holds the phase sampled on that edge
  always @(negedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) psg_regs[i] <= 8'h00;
      psg_addr <= 4'h0;
    end else if (ce) begin
      phase_log.push_back({bdir, bc1, d});
      if (bdir && bc1) begin
        if (d[7:4] == 4'h0) psg_addr <= d[3:0];
      end else if (bdir && !bc1) begin
        psg_regs[psg_addr] <= d;
        if (psg_addr == 4'd13) env_resets <= env_resets + 1;
        if (exp_wr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_write unexpected actual=%0h required=none", {psg_addr, d});
        end else begin
          sb_exp = exp_wr_q.pop_front();
          chk("sb_write", {20'd0, psg_addr, d}, {20'd0, sb_exp});
        end
      end
    end
  end

  // ---------------- helpers ----------------
  int         log_start;
  logic [9:0] exp_seq [$];

  task automatic push(input logic [3:0] r, input logic [7:0] dv, output bit acc);
    @(negedge clock);
    wr_valid = 1'b1;
    wr_reg   = r;
    wr_data  = dv;
    acc      = wr_ready;
    @(posedge clock);
    #1;
    wr_valid = 1'b0;
    if (acc) exp_wr_q.push_back({r, dv});
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (busy) chk({name, "_idle_timeout"}, busy, 1'b0);
    chk({name, "_sb_drained"}, exp_wr_q.size(), 0);
  endtask

  // Non-idle phases since log_start must match exp_seq back-to-back from the first one
  task automatic check_seq(input string name);
    int first;
    int nz;
    int exp_nz;
    int idx;
    first  = -1;
    nz     = 0;
    exp_nz = 0;
    for (int i = log_start; i < phase_log.size(); i++) begin
      if (phase_log[i] != 10'd0) begin
        if (first < 0) first = i;
        nz++;
      end
    end
    foreach (exp_seq[k]) if (exp_seq[k] != 10'd0) exp_nz++;
    chk({name, "_nonidle_count"}, nz, exp_nz);
    if (first < 0) first = log_start;
    foreach (exp_seq[k]) begin
      idx = first + k;
      chk($sformatf("%s_phase%0d", name, k),
          (idx < phase_log.size()) ? {22'd0, phase_log[idx]} : 32'hFFFF,
          {22'd0, exp_seq[k]});
    end
  endtask

  typedef struct {
    logic [3:0] r;
    logic [7:0] dat;
    bit         miss;
  } vec_t;

  vec_t vecs [6];

  // ---------------- main sequence ----------------
  initial begin
    bit acc;
    int n_acc;
    int n;
    int done_cnt;
    int env0;

    vecs[0] = '{4'd7,  8'h38, 1'b1};
    vecs[1] = '{4'd7,  8'h55, 1'b0};
    vecs[2] = '{4'd3,  8'hAA, 1'b1};
    vecs[3] = '{4'd3,  8'h00, 1'b0};
    vecs[4] = '{4'd15, 8'hFF, 1'b1};
    vecs[5] = '{4'd7,  8'h12, 1'b1};

    // reset values
    repeat (4) @(posedge clock);
    #1;
    chk("rst_bdir", bdir, 1'b0);
    chk("rst_bc1", bc1, 1'b0);
    chk("rst_d", d, 8'h00);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_rd_done", rd_done, 1'b0);
    chk("rst_wr_ready", wr_ready, 1'b1);
    chk("rst_rd_ready", rd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    @(negedge clock);
    reset  = 1'b1;
    ce_run = 1'b1;

    // single writes from an idle engine, with and without address cache hits
    for (int i = 0; i < 6; i++) begin
      log_start = phase_log.size();
      push(vecs[i].r, vecs[i].dat, acc);
      chk($sformatf("vec%0d_accepted", i), acc, 1'b1);
      chk($sformatf("vec%0d_wr_ready", i), wr_ready, 1'b1);
      wait_idle($sformatf("vec%0d", i), 200);
      exp_seq.delete();
      if (vecs[i].miss) exp_seq.push_back({2'b11, 4'h0, vecs[i].r});
      exp_seq.push_back({2'b10, vecs[i].dat});
      exp_seq.push_back(10'd0);
      check_seq($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_psg_reg", i), psg_regs[vecs[i].r], vecs[i].dat);
    end

    // two back-to-back writes to R0: one ADDR, then WDATA/GAP twice
    log_start = phase_log.size();
    push(4'd0, 8'h11, acc);
    push(4'd0, 8'h22, acc);
    wait_idle("b2b", 200);
    exp_seq = '{10'h300, 10'h211, 10'h000, 10'h222, 10'h000};
    check_seq("b2b");
    chk("b2b_psg_r0", psg_regs[0], 8'h22);

    // two identical R13 writes must each be a distinct write pulse
    env0      = env_resets;
    log_start = phase_log.size();
    push(4'd13, 8'h0E, acc);
    push(4'd13, 8'h0E, acc);
    wait_idle("r13", 200);
    exp_seq = '{10'h30D, 10'h20E, 10'h000, 10'h20E, 10'h000};
    check_seq("r13");
    chk("r13_env_resets", env_resets - env0, 2);

    // fill the FIFO with ce held low, then drain
    ce_run = 1'b0;
    repeat (3) @(posedge clock);
    n_acc = 0;
    for (int i = 0; i < 9; i++) begin
      push(4'(i), 8'h40 + 8'(i), acc);
      if (acc) n_acc++;
      if (i == 7) chk("fill_wr_ready_full", wr_ready, 1'b0);
    end
    chk("fill_accepted", n_acc, 8);
    chk("fill_no_bus_activity", {bdir, bc1}, 2'b00);
    ce_run = 1'b1;
    n = 0;
    while (!ce && n < 10) begin
      @(negedge clock);
      n++;
    end
    chk("fill_ce_seen", ce, 1'b1);
    @(posedge clock);
    #1;
    chk("fill_wr_ready_after_pop", wr_ready, 1'b1);
    wait_idle("fill", 600);
    chk("fill_psg_r0", psg_regs[0], 8'h40);
    chk("fill_psg_r7", psg_regs[7], 8'h47);

    // write R8, read R8, and a write to R2 queued while the read is pending
    log_start = phase_log.size();
    push(4'd8, 8'h0F, acc);
    @(negedge clock);
    rd_valid = 1'b1;
    rd_reg   = 4'd8;
    chk("rd_ready_before", rd_ready, 1'b1);
    @(posedge clock);
    #1;
    rd_valid = 1'b0;
    chk("rd_ready_pending", rd_ready, 1'b0);
    push(4'd2, 8'h5A, acc);
    n        = 0;
    done_cnt = 0;
    while (busy && n < 400) begin
      @(negedge clock);
      n++;
      if (rd_done) begin
        done_cnt++;
        chk("rd_data_at_done", rd_data, 8'h0F);
        chk("rd_ready_at_done", rd_ready, 1'b1);
      end
    end
    if (busy) chk("rd_idle_timeout", busy, 1'b0);
    @(negedge clock);
    chk("rd_done_pulses", done_cnt + int'(rd_done), 1);
    chk("rd_data_held", rd_data, 8'h0F);
    exp_seq = '{10'h308, 10'h20F, 10'h000, 10'h302, 10'h25A, 10'h000,
                10'h308, 10'h100, 10'h000};
    check_seq("rd");
    chk("rd_psg_r2", psg_regs[2], 8'h5A);

    // reset during an ADDR phase with three entries still queued
    ce_run = 1'b0;
    repeat (3) @(posedge clock);
    for (int i = 0; i < 4; i++) push(4'd5, 8'h61 + 8'(i), acc);
    ce_run = 1'b1;
    n = 0;
    while (!(bdir && bc1) && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("rst_mid_addr_seen", {bdir, bc1, d}, 10'h305);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid_bdir", bdir, 1'b0);
    chk("rst_mid_bc1", bc1, 1'b0);
    chk("rst_mid_wr_ready", wr_ready, 1'b1);
    chk("rst_mid_busy", busy, 1'b0);
    exp_wr_q.delete();
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    chk("rst_post_busy", busy, 1'b0);
    log_start = phase_log.size();
    push(4'd5, 8'h77, acc);
    wait_idle("post_rst", 200);
    exp_seq = '{10'h305, 10'h277, 10'h000};
    check_seq("post_rst");
    chk("post_rst_psg_r5", psg_regs[5], 8'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
